// File: rtl/wb_periph_arb.sv
// rtl/wb_periph_arb.sv - two-master round-robin arbiter onto one shared peripheral bus (optional watchdog: WB_ARB_TIMEOUT_EN)
module wb_periph_arb #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wmsk,
    input  logic        m0_we,
    input  logic        m0_cyc,
    output logic [31:0] m0_rdata,
    output logic        m0_ack,
    input  logic [15:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wmsk,
    input  logic        m1_we,
    input  logic        m1_cyc,
    output logic [31:0] m1_rdata,
    output logic        m1_ack,
    output logic [15:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wmsk,
    output logic        s_we,
    output logic        s_cyc,
    input  logic [31:0] s_rdata,
    input  logic        s_ack,
    output logic        to_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS0 = 2'd1,
        BUS1 = 2'd2
    } state_t;

    state_t state;
    logic   prio;       // 1: a contested grant goes to m1
    logic   gnt_cyc;    // granted master still holding its request
    logic   to_hit;     // watchdog expired this cycle
    logic   done;       // transaction completes this cycle (ack or timeout)

    // cyc of the currently granted master; zero in IDLE so s_ack is ignored there
    assign gnt_cyc = (state == BUS0) ? m0_cyc :
                     (state == BUS1) ? m1_cyc : 1'b0;

`ifdef WB_ARB_TIMEOUT_EN
    localparam logic [7:0] TO_LIM = 8'(TIMEOUT);
    logic [7:0] wd_cnt;

    // watchdog: zero while idle so every BUSn entry starts from 0, then count un-acked cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt <= '0;
        end else if (state == IDLE) begin
            wd_cnt <= '0;
        end else if (!s_ack) begin
            wd_cnt <= wd_cnt + 8'd1;
        end
    end

    assign to_hit = gnt_cyc && !s_ack && (wd_cnt == TO_LIM);
`else
    assign to_hit = 1'b0;
`endif

    // an abort (granted cyc low) masks any coincident s_ack
    assign done     = gnt_cyc && (s_ack || to_hit);
    assign m0_ack   = (state == BUS0) && done;
    assign m1_ack   = (state == BUS1) && done;
    assign m0_rdata = to_hit ? 32'hFFFF_FFFF : s_rdata;
    assign m1_rdata = to_hit ? 32'hFFFF_FFFF : s_rdata;
    assign to_err   = to_hit;

    // arbitration FSM with registered shared-bus outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            prio    <= 1'b0;
            s_cyc   <= 1'b0;
            s_we    <= 1'b0;
            s_addr  <= '0;
            s_wdata <= '0;
            s_wmsk  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (m0_cyc && !(m1_cyc && prio)) begin
                        state   <= BUS0;
                        s_cyc   <= 1'b1;
                        s_we    <= m0_we;
                        s_addr  <= m0_addr;
                        s_wdata <= m0_wdata;
                        s_wmsk  <= m0_wmsk;
                    end else if (m1_cyc) begin
                        state   <= BUS1;
                        s_cyc   <= 1'b1;
                        s_we    <= m1_we;
                        s_addr  <= m1_addr;
                        s_wdata <= m1_wdata;
                        s_wmsk  <= m1_wmsk;
                    end
                end
                BUS0, BUS1: begin
                    if (!gnt_cyc) begin
                        // abort: leave priority untouched
                        state <= IDLE;
                        s_cyc <= 1'b0;
                    end else if (done) begin
                        state <= IDLE;
                        s_cyc <= 1'b0;
                        prio  <= (state == BUS0);
                    end
                end
                default: begin
                    state <= IDLE;
                    s_cyc <= 1'b0;
                end
            endcase
        end
    end

endmodule
